// File: rtl/mcpu_bus_ctrl.sv
// Memory-mapped bus controller: decodes the top address bits into a channel and runs a req/ack access with timeout.
// Optional fault log (fault_clr/fault_addr/fault_cnt) is built when MCPU_BUS_FAULT_LOG_EN is defined.
module mcpu_bus_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int SEL_BITS   = 2,
    localparam int NUM_CH    = 2 ** SEL_BITS,
    localparam int OFF_W     = ADDR_WIDTH - SEL_BITS,
    parameter logic [NUM_CH-1:0] CH_MASK = '1,
    parameter int TIMEOUT    = 15
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [ADDR_WIDTH-1:0]        cpu_addr,
    input  logic [DATA_WIDTH-1:0]        cpu_wdata,
    input  logic                         cpu_re,
    input  logic                         cpu_we,
    output logic [DATA_WIDTH-1:0]        cpu_rdata,
    output logic                         cpu_ready,
    output logic                         cpu_err,
    output logic [OFF_W-1:0]             ch_addr,
    output logic [DATA_WIDTH-1:0]        ch_wdata,
    output logic [NUM_CH-1:0]            ch_re,
    output logic [NUM_CH-1:0]            ch_we,
    input  logic [NUM_CH*DATA_WIDTH-1:0] ch_rdata,
    input  logic [NUM_CH-1:0]            ch_ack
`ifdef MCPU_BUS_FAULT_LOG_EN
    ,
    input  logic                         fault_clr,
    output logic [ADDR_WIDTH-1:0]        fault_addr,
    output logic [7:0]                   fault_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t                  state_q, state_d;
    logic [7:0]              cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    rd_q;
    logic [NUM_CH-1:0]       re_d, we_d;
    logic                    ready_d, err_d, load_req, capture;
    logic [SEL_BITS-1:0]     req_sel, sel_q;
    logic [DATA_WIDTH-1:0]   sel_rdata;

    assign req_sel   = cpu_addr[ADDR_WIDTH-1 -: SEL_BITS];
    assign sel_q     = addr_q[ADDR_WIDTH-1 -: SEL_BITS];
    assign sel_rdata = ch_rdata[sel_q*DATA_WIDTH +: DATA_WIDTH];
    assign ch_addr   = addr_q[OFF_W-1:0];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        re_d     = '0;
        we_d     = '0;
        ready_d  = 1'b0;
        err_d    = 1'b0;
        load_req = 1'b0;
        capture  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_re ^ cpu_we) begin
                    load_req = 1'b1;
                    if (!CH_MASK[req_sel]) begin
                        state_d = DONE;
                        ready_d = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d       = ACCESS;
                        cnt_d         = 8'd0;
                        re_d[req_sel] = cpu_re;
                        we_d[req_sel] = cpu_we;
                    end
                end else if (cpu_re && cpu_we) begin
                    // Latch the address anyway so a fault log records it.
                    load_req = 1'b1;
                    state_d  = DONE;
                    ready_d  = 1'b1;
                    err_d    = 1'b1;
                end
            end
            ACCESS: begin
                // Ack takes priority over the final timeout cycle.
                if (ch_ack[sel_q]) begin
                    state_d = DONE;
                    ready_d = 1'b1;
                    capture = rd_q;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    ready_d = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    re_d  = ch_re;
                    we_d  = ch_we;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 8'd0;
            addr_q    <= '0;
            rd_q      <= 1'b0;
            ch_wdata  <= '0;
            ch_re     <= '0;
            ch_we     <= '0;
            cpu_ready <= 1'b0;
            cpu_err   <= 1'b0;
            cpu_rdata <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ch_re     <= re_d;
            ch_we     <= we_d;
            cpu_ready <= ready_d;
            cpu_err   <= err_d;
            if (load_req) begin
                addr_q   <= cpu_addr;
                ch_wdata <= cpu_wdata;
                rd_q     <= cpu_re;
            end
            if (capture) cpu_rdata <= sel_rdata;
        end
    end

`ifdef MCPU_BUS_FAULT_LOG_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fault_addr <= '0;
            fault_cnt  <= 8'd0;
        end else if (fault_clr) begin
            fault_addr <= '0;
            fault_cnt  <= 8'd0;
        end else if (state_q == DONE && cpu_err) begin
            fault_addr <= addr_q;
            if (fault_cnt != 8'hFF) fault_cnt <= fault_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mcpu_bus_ctrl.sv
// Directed bench for mcpu_bus_ctrl: reads, writes, timeout, masked channel, re&we, reset mid-access.
// A second instance with channel 3 disabled covers the masked-channel error path.
module tb_mcpu_bus_ctrl;

    logic        clk;
    logic        reset;
    logic [15:0] cpu_addr, cpu_wdata;
    logic        cpu_re, cpu_we;
    logic [15:0] cpu_rdata;
    logic        cpu_ready, cpu_err;
    logic [13:0] ch_addr;
    logic [15:0] ch_wdata;
    logic [3:0]  ch_re, ch_we;
    logic [63:0] ch_rdata;
    logic [3:0]  ch_ack;

    logic [15:0] m_addr;
    logic        m_re;
    logic [15:0] m_rdata;
    logic        m_ready, m_err;
    logic [13:0] m_ch_addr;
    logic [15:0] m_ch_wdata;
    logic [3:0]  m_ch_re, m_ch_we;

`ifdef MCPU_BUS_FAULT_LOG_EN
    logic        fault_clr;
    logic [15:0] fault_addr, m_fault_addr;
    logic [7:0]  fault_cnt, m_fault_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] exp_q[$];

    mcpu_bus_ctrl dut (
        .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_rdata(cpu_rdata),
        .cpu_ready(cpu_ready), .cpu_err(cpu_err), .ch_addr(ch_addr),
        .ch_wdata(ch_wdata), .ch_re(ch_re), .ch_we(ch_we),
        .ch_rdata(ch_rdata), .ch_ack(ch_ack)
`ifdef MCPU_BUS_FAULT_LOG_EN
        , .fault_clr(fault_clr), .fault_addr(fault_addr), .fault_cnt(fault_cnt)
`endif
    );

    mcpu_bus_ctrl #(.CH_MASK(4'b0111)) dut_m (
        .clk(clk), .reset(reset), .cpu_addr(m_addr), .cpu_wdata(16'h0000),
        .cpu_re(m_re), .cpu_we(1'b0), .cpu_rdata(m_rdata),
        .cpu_ready(m_ready), .cpu_err(m_err), .ch_addr(m_ch_addr),
        .ch_wdata(m_ch_wdata), .ch_re(m_ch_re), .ch_we(m_ch_we),
        .ch_rdata(ch_rdata), .ch_ack(ch_ack)
`ifdef MCPU_BUS_FAULT_LOG_EN
        , .fault_clr(fault_clr), .fault_addr(m_fault_addr), .fault_cnt(m_fault_cnt)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_rdata();
        return (exp_q.size() > 0) ? exp_q[$] : 16'h0000;
    endfunction

    // results of the last run_access
    int          r_lat, r_strobes;
    logic [3:0]  r_re_vec, r_we_vec;
    logic [13:0] r_addr;
    logic [15:0] r_wdata;
    logic        r_ready, r_err;

    // Drive one CPU access; ack channel ack_ch during its ack_at-th strobe cycle (0 = never).
    task automatic run_access(input logic [15:0] addr, input logic [15:0] wdata,
                              input logic re, input logic we, input int ack_ch,
                              input int ack_at, input logic [3:0] noise);
        int cycles;
        cycles    = 0;
        r_strobes = 0;
        r_re_vec  = '0;
        r_we_vec  = '0;
        r_addr    = '0;
        r_wdata   = '0;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        cpu_re    = re;
        cpu_we    = we;
        ch_ack    = noise;
        tick();
        while (!cpu_ready && cycles < 40) begin
            if (|ch_re || |ch_we) begin
                r_strobes++;
                r_re_vec |= ch_re;
                r_we_vec |= ch_we;
                r_addr   = ch_addr;
                r_wdata  = ch_wdata;
                if (r_strobes == ack_at) ch_ack[ack_ch] = 1'b1;
            end
            tick();
            cycles++;
        end
        r_lat   = cycles + 1;
        r_ready = cpu_ready;
        r_err   = cpu_err;
        cpu_re  = 1'b0;
        cpu_we  = 1'b0;
        ch_ack  = '0;
        check("ready_seen", {31'd0, r_ready}, 32'd1);
        tick();
        check("ready_pulse", {30'd0, cpu_ready, cpu_err}, 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        cpu_addr  = '0;
        cpu_wdata = '0;
        cpu_re    = 1'b0;
        cpu_we    = 1'b0;
        ch_rdata  = '0;
        ch_ack    = '0;
        m_addr    = '0;
        m_re      = 1'b0;
`ifdef MCPU_BUS_FAULT_LOG_EN
        fault_clr = 1'b0;
`endif
        repeat (2) tick();
        check("rst_rdata", {16'd0, cpu_rdata}, 32'd0);
        check("rst_ctrl", {26'd0, cpu_ready, cpu_err, ch_re}, 32'd0);
        check("rst_we", {28'd0, ch_we}, 32'd0);
        check("rst_chaddr", {2'd0, ch_addr, ch_wdata}, 32'd0);
        reset = 1'b0;
        tick();

        // 1: zero-wait read on channel 1
        ch_rdata[16 +: 16] = 16'hBEEF;
        exp_q.push_back(16'hBEEF);
        run_access(16'h4012, 16'h0000, 1'b1, 1'b0, 1, 1, 4'b0000);
        check("t1_re", {28'd0, r_re_vec}, 32'h2);
        check("t1_addr", {18'd0, r_addr}, 32'h0012);
        check("t1_lat", r_lat, 2);
        check("t1_err", {31'd0, r_err}, 0);
        check("t1_rdata", {16'd0, cpu_rdata}, {16'd0, exp_rdata()});

        // 1b: acks from other channels are ignored
        ch_rdata[16 +: 16] = 16'h1357;
        exp_q.push_back(16'h1357);
        run_access(16'h4000, 16'h0000, 1'b1, 1'b0, 1, 2, 4'b1001);
        check("t1b_strobes", r_strobes, 2);
        check("t1b_lat", r_lat, 3);
        check("t1b_rdata", {16'd0, cpu_rdata}, {16'd0, exp_rdata()});

        // 2: write to channel 2, ack on the 4th strobe cycle
        run_access(16'h8005, 16'h00A5, 1'b0, 1'b1, 2, 4, 4'b0000);
        check("t2_we", {24'd0, r_re_vec, r_we_vec}, 32'h04);
        check("t2_strobes", r_strobes, 4);
        check("t2_wdata", {16'd0, r_wdata}, 32'h00A5);
        check("t2_lat", r_lat, 5);
        check("t2_err", {31'd0, r_err}, 0);
        check("t2_rdata", {16'd0, cpu_rdata}, {16'd0, exp_rdata()});

        // 3: channel 3 never acks -> timeout after 15 strobe cycles
        run_access(16'hC000, 16'h0000, 1'b1, 1'b0, 3, 0, 4'b0000);
        check("t3_re", {28'd0, r_re_vec}, 32'h8);
        check("t3_strobes", r_strobes, 15);
        check("t3_lat", r_lat, 16);
        check("t3_err", {31'd0, r_err}, 1);
        check("t3_rdata", {16'd0, cpu_rdata}, {16'd0, exp_rdata()});

        // 3b: ack on the last cycle before timeout wins
        ch_rdata[48 +: 16] = 16'hA5A5;
        exp_q.push_back(16'hA5A5);
        run_access(16'hC0FF, 16'h0000, 1'b1, 1'b0, 3, 15, 4'b0000);
        check("t3b_strobes", r_strobes, 15);
        check("t3b_err", {31'd0, r_err}, 0);
        check("t3b_rdata", {16'd0, cpu_rdata}, {16'd0, exp_rdata()});

        // 4: masked channel on the second instance
        m_addr = 16'hC001;
        m_re   = 1'b1;
        tick();
        check("t4_ready_err", {30'd0, m_ready, m_err}, 32'h3);
        check("t4_strobe", {28'd0, m_ch_re | m_ch_we}, 32'h0);
        m_re = 1'b0;
        tick();
        check("t4_idle", {30'd0, m_ready, m_err}, 32'h0);

        // 5: read and write together
        run_access(16'h4444, 16'h1111, 1'b1, 1'b1, 0, 0, 4'b0000);
        check("t5_strobes", r_strobes, 0);
        check("t5_lat", r_lat, 1);
        check("t5_err", {31'd0, r_err}, 1);
        check("t5_rdata", {16'd0, cpu_rdata}, {16'd0, exp_rdata()});
`ifdef MCPU_BUS_FAULT_LOG_EN
        check("fl_cnt", {24'd0, fault_cnt}, 32'd2);
        check("fl_addr", {16'd0, fault_addr}, 32'h4444);
        check("fl_m_cnt", {24'd0, m_fault_cnt}, 32'd1);
        check("fl_m_addr", {16'd0, m_fault_addr}, 32'hC001);
`endif

        // 6: reset in the middle of an access
        cpu_addr = 16'h8000;
        cpu_re   = 1'b1;
        tick();
        tick();
        check("t6_strobe", {28'd0, ch_re}, 32'h4);
        #2 reset = 1'b1;
        #1;
        check("t6_async", {28'd0, ch_re}, 32'h0);
        cpu_re = 1'b0;
        tick();
        check("t6_noready", {30'd0, cpu_ready, cpu_err}, 32'h0);
        check("t6_rdata", {16'd0, cpu_rdata}, 32'h0);
`ifdef MCPU_BUS_FAULT_LOG_EN
        check("fl_rst", {8'd0, fault_cnt, fault_addr}, 32'h0);
`endif
        exp_q.delete();
        reset = 1'b0;
        tick();
        check("t6_postrst", {30'd0, cpu_ready, cpu_err}, 32'h0);
        ch_rdata[0 +: 16] = 16'h1234;
        exp_q.push_back(16'h1234);
        run_access(16'h0000, 16'h0000, 1'b1, 1'b0, 0, 1, 4'b0000);
        check("t6_re", {28'd0, r_re_vec}, 32'h1);
        check("t6_err", {31'd0, r_err}, 0);
        check("t6_read", {16'd0, cpu_rdata}, {16'd0, exp_rdata()});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
